// File: rtl/sequence_generator.sv
// sequence_generator
// 16 MHz master-sequence generator: an 8-stage Johnson counter producing
// S[7:0] with phase decode, a cycle-boundary strobe, halt-at-phase control
// and one-clock recovery from illegal states.
// Optional debug feature (macro SEQ_DEBUG_EN): direct load of S and a
// saturating recovery counter.
module sequence_generator #(
  parameter logic [3:0] HALT_PHASE = 4'd0
`ifdef SEQ_DEBUG_EN
  , parameter int ERR_CNT_W = 8
`endif
) (
  input  logic                 CLK_n,
  input  logic                 RESET_n,
  input  logic                 HALT_REQ,
`ifdef SEQ_DEBUG_EN
  input  logic                 LOAD_EN,
  input  logic [7:0]           LOAD_S,
  output logic [ERR_CNT_W-1:0] ERR_CNT,
`endif
  output logic [7:0]           S,
  output logic [3:0]           PHASE,
  output logic                 CYCLE_STB,
  output logic                 HALTED,
  output logic                 SEQ_ERR
);

  // A legal Johnson state is a run of ones anchored at bit 0 (00,01..FF)
  // or a run of zeros anchored at bit 0 (FE..80). Either form is 2^k-1
  // in S or in ~S, which the x & (x+1) test detects.
  function automatic logic seq_legal(input logic [7:0] s);
    logic [7:0] inv;
    inv = ~s;
    return (((s & (s + 8'd1)) == 8'd0) || ((inv & (inv + 8'd1)) == 8'd0));
  endfunction

  // Phase index from the ones count. The second half of the sequence is
  // 16 - ones; in 4-bit arithmetic that is simply 0 - ones.
  function automatic logic [3:0] seq_phase(input logic [7:0] s);
    logic [3:0] ones;
    logic [3:0] ph;
    ones = 4'd0;
    for (int i = 0; i < 8; i++) begin
      ones = ones + {3'd0, s[i]};
    end
    if (!seq_legal(s)) begin
      ph = 4'd0;
    end else if (s[0] || (s == 8'd0)) begin
      ph = ones;
    end else begin
      ph = 4'd0 - ones;
    end
    return ph;
  endfunction

  logic [7:0] s_r;
  logic       halted_r;
  logic       seq_err_r;

  logic [7:0] s_nxt_s;
  logic       halted_nxt_s;
  logic       seq_err_nxt_s;
  logic       legal_s;
  logic [3:0] phase_s;
  logic       recover_s;

  assign legal_s = seq_legal(s_r);
  assign phase_s = seq_phase(s_r);

  // Next-state selection: load (debug), recovery, halt, then advance.
  always_comb begin
    s_nxt_s       = s_r;
    halted_nxt_s  = 1'b0;
    seq_err_nxt_s = 1'b0;
    recover_s     = 1'b0;
`ifdef SEQ_DEBUG_EN
    if (LOAD_EN) begin
      s_nxt_s       = LOAD_S;
      halted_nxt_s  = 1'b0;
      seq_err_nxt_s = 1'b0;
    end else
`endif
    if (!legal_s) begin
      s_nxt_s       = 8'h00;
      halted_nxt_s  = 1'b0;
      seq_err_nxt_s = 1'b1;
      recover_s     = 1'b1;
    end else if (HALT_REQ && (phase_s == HALT_PHASE)) begin
      s_nxt_s       = s_r;
      halted_nxt_s  = 1'b1;
    end else begin
      s_nxt_s       = {s_r[6:0], ~s_r[7]};
      halted_nxt_s  = 1'b0;
    end
  end

  // Sequence state and status flags.
  always_ff @(posedge CLK_n or negedge RESET_n) begin
    if (!RESET_n) begin
      s_r       <= 8'h00;
      halted_r  <= 1'b0;
      seq_err_r <= 1'b0;
    end else begin
      s_r       <= s_nxt_s;
      halted_r  <= halted_nxt_s;
      seq_err_r <= seq_err_nxt_s;
    end
  end

`ifdef SEQ_DEBUG_EN
  logic [ERR_CNT_W-1:0] err_cnt_r;

  // Saturating count of recoveries.
  always_ff @(posedge CLK_n or negedge RESET_n) begin
    if (!RESET_n) begin
      err_cnt_r <= '0;
    end else if (recover_s && (err_cnt_r != {ERR_CNT_W{1'b1}})) begin
      err_cnt_r <= err_cnt_r + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign ERR_CNT = err_cnt_r;
`else
  logic unused_recover_s;
  assign unused_recover_s = recover_s;
`endif

  assign S         = s_r;
  assign PHASE     = phase_s;
  assign HALTED    = halted_r;
  assign SEQ_ERR   = seq_err_r;
  assign CYCLE_STB = (phase_s == 4'd15) & ~halted_r;

endmodule
